// File: rtl/div32_iter.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Computes one quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div32_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Two's complement negation modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
      return '0 - v;
   endfunction

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? neg2c(v) : v;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_result;
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;

   logic             w_accept;
   logic             w_signed;
   logic             w_is_rem;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_special;
   logic [WIDTH-1:0] w_special_val;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic             w_last;
   logic [WIDTH-1:0] w_fin_val;
   logic             w_unused;

   // Accept decode: start is honoured whenever the unit is not iterating.
   assign w_accept = start && (r_state != CALC);
   assign w_signed = ~op[0];
   assign w_is_rem = op[1];
   assign w_a_mag  = mag(a, w_signed);
   assign w_b_mag  = mag(b, w_signed);

   assign w_b_zero  = (b == '0);
   assign w_ovf     = w_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
   assign w_special = w_b_zero || w_ovf;

   always_comb begin
      w_special_val = '0;
      if (w_b_zero) begin
         w_special_val = w_is_rem ? a : '1;
      end else if (w_ovf) begin
         w_special_val = w_is_rem ? '0 : a;
      end
   end

   // One restoring step: shift in the next dividend bit and trial-subtract on WIDTH+1 bits.
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_dvs};
   assign w_borrow  = w_diff[WIDTH+1];
   // The kept remainder is always below the divisor, so it fits in WIDTH bits.
   assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign w_unused  = w_diff[WIDTH];

   always_comb begin
      w_fin_val = '0;
      if (r_is_rem) begin
         w_fin_val = r_neg_r ? neg2c(w_rem_nxt) : w_rem_nxt;
      end else begin
         w_fin_val = r_neg_q ? neg2c(w_quo_nxt) : w_quo_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, FIN: begin
            if (start) begin
               w_state_nxt = w_special ? FIN : CALC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            if (w_last) begin
               w_state_nxt = FIN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath registers: latched on accept, stepped in CALC, result captured entering FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_result <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= w_a_mag;
         r_dvs    <= w_b_mag;
         r_is_rem <= w_is_rem;
         r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_neg_r  <= w_signed && a[WIDTH-1];
         if (w_special) begin
            r_result <= w_special_val;
         end
      end else if (r_state == CALC) begin
         r_cnt <= r_cnt + CW'(1);
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         if (w_last) begin
            r_result <= w_fin_val;
         end
      end
   end

   assign busy   = (r_state == CALC);
   assign done   = (r_state == FIN);
   assign result = r_result;

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: directed vector table, handshake/reset
// sequences, and random operations against an arithmetic reference model.
module tb_div32_iter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp;
   int n_bad;

   div32_iter #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      string       nm;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic plus the RV32M divide-by-zero rule.
   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sx;
      longint sy;
      if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00:   return 32'(sx / sy);
         2'b01:   return x / y;
         2'b10:   return 32'(sx % sy);
         default: return x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 32'd0) return 1;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Called #1 after a rising edge with the unit idle.
   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input int el);
      int lat;
      int bc;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      bc    = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " result"}, result, er);
      chk({nm, " latency"}, 32'(lat), 32'(el));
      chk({nm, " busy_cycles"}, 32'(bc), 32'(el - 1));
      @(posedge clk);
      #1;
      chk({nm, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({nm, " result_hold"}, result, er);
   endtask

   initial begin
      vec_t vt[14];
      int   lat;
      int   dcnt;
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      int   sel;

      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;

      vt[0]  = '{2'b01, 32'd100,         32'd7,           32'd14,          33, "divu_100_7"};
      vt[1]  = '{2'b11, 32'd100,         32'd7,           32'd2,           33, "remu_100_7"};
      vt[2]  = '{2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33, "div_m7_2"};
      vt[3]  = '{2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33, "rem_m7_2"};
      vt[4]  = '{2'b00, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   33, "div_7_m2"};
      vt[5]  = '{2'b01, 32'h0000_1234,   32'd0,           32'hFFFF_FFFF,   1,  "divu_by0"};
      vt[6]  = '{2'b10, 32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9,   1,  "rem_by0"};
      vt[7]  = '{2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1,  "div_ovf"};
      vt[8]  = '{2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1,  "rem_ovf"};
      vt[9]  = '{2'b01, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           33, "divu_big"};
      vt[10] = '{2'b01, 32'd0,           32'd5,           32'd0,           33, "divu_zero_a"};
      vt[11] = '{2'b11, 32'd5,           32'd0,           32'd5,           1,  "remu_by0"};
      vt[12] = '{2'b10, 32'd7,           32'hFFFF_FFFE,   32'd1,           33, "rem_7_m2"};
      vt[13] = '{2'b00, 32'h8000_0000,   32'd2,           32'hC000_0000,   33, "div_min_2"};

      #12;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);
      end

      // Start pulsed mid-operation must be ignored.
      op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      repeat (4) begin
         @(posedge clk);
         #1;
         lat++;
      end
      a = 32'd9; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("ignore result", result, 32'd14);
      chk("ignore latency", 32'(lat), 32'd33);
      dcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) dcnt++;
      end
      chk("ignore no_second_op", 32'(dcnt), 32'd0);

      // Start held through FIN launches the next operation from FIN.
      op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b first result", result, 32'd14);
      chk("b2b first latency", 32'(lat), 32'd33);
      op = 2'b11;
      @(posedge clk);
      #1;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      chk("b2b second result", result, 32'd2);
      chk("b2b second latency", 32'(lat), 32'd33);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of an iteration.
      op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort result", result, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) dcnt++;
      end
      chk("abort no_done", 32'(dcnt), 32'd0);
      run_op("post_reset", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         rx  = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       ry = 32'd0;
            1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            2:       ry = $urandom_range(1, 15);
            3:       ry = 32'd0 - 32'($urandom_range(1, 15));
            4: begin rx = $urandom_range(0, 1000); ry = $urandom; end
            default: ry = $urandom;
         endcase
         run_op("random", ro, rx, ry, ref_model(ro, rx, ry), ref_lat(ro, rx, ry));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
